// File: rtl/bus_ram_if.sv
// Shared system-bus signals seen by a memory responder. The tristate nets carry
// the bus proper; the drive-enable flags expose when the responder owns them.
interface bus_ram_if;
    logic [31:0] addr_bus;
    wire  [31:0] data_bus;
    logic        rd_bus;
    logic        wr_bus;
    logic [3:0]  data_mask_bus;
    wire         fc_bus;
    logic        fc_oe;
    logic        data_oe;

    modport slave (
        input  addr_bus, rd_bus, wr_bus, data_mask_bus,
        inout  data_bus, fc_bus,
        output fc_oe, data_oe
    );

    modport master (
        output addr_bus, rd_bus, wr_bus, data_mask_bus,
        inout  data_bus, fc_bus,
        input  fc_oe, data_oe
    );
endinterface

// File: rtl/bus_ram.sv
// Word-organised bus RAM responder: window decode, programmable wait states,
// masked right-aligned writes, right-aligned reads, completion held until release.
module bus_ram #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          SIZE_WORDS = 1024,
    parameter int          READ_WAIT  = 1,
    parameter int          WRITE_WAIT = 0
) (
    input  logic      clk,
    input  logic      rst,
    bus_ram_if.slave  bus
);
    localparam int AW = $clog2(SIZE_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [31:0]    lat_addr;
    logic [3:0]     lat_mask;
    logic           lat_rd;
    logic [31:0]    rdata;

    logic           hit, valid, req, match, commit;
    logic [3:0]     wait_sel;
    logic [AW-1:0]  idx;
    logic [1:0]     off;
    logic [3:0]     cur_mask;
    logic           cur_rd;
    logic [3:0]     be;
    logic [31:0]    wbyte;
    logic [31:0]    rd_word;
    logic [1:0]     lane;

    logic [31:0]    mem [SIZE_WORDS];

    // Window is aligned to its size, so a hit is an upper-bit compare.
    assign hit      = bus.addr_bus[31:AW+2] == BASE_ADDR[31:AW+2];
    assign valid    = bus.rd_bus ^ bus.wr_bus;
    assign req      = hit && valid;
    assign match    = req && (bus.addr_bus == lat_addr) && (bus.rd_bus == lat_rd);
    assign wait_sel = bus.rd_bus ? 4'(READ_WAIT) : 4'(WRITE_WAIT);

    // In IDLE the access comes straight off the bus (zero-wait case); later from the latches.
    assign idx      = (state == IDLE) ? bus.addr_bus[AW+1:2] : lat_addr[AW+1:2];
    assign off      = (state == IDLE) ? bus.addr_bus[1:0]    : lat_addr[1:0];
    assign cur_mask = (state == IDLE) ? bus.data_mask_bus    : lat_mask;
    assign cur_rd   = (state == IDLE) ? bus.rd_bus           : lat_rd;

    always_comb begin
        commit = 1'b0;
        case (state)
            IDLE:    commit = req && (wait_sel == 4'd0);
            WAIT:    commit = match && (cnt == 4'd1);
            default: commit = 1'b0;
        endcase
    end

    // Destination byte j takes lane j-off; lanes shifted past byte 3 fall off.
    always_comb begin
        be    = '0;
        wbyte = '0;
        lane  = '0;
        for (int j = 0; j < 4; j++) begin
            lane = 2'(j) - off;
            if (2'(j) >= off) begin
                be[j]           = cur_mask[lane];
                wbyte[8*j +: 8] = bus.data_bus[{lane, 3'b000} +: 8];
            end
        end
    end

    assign rd_word = mem[idx] >> {off, 3'b000};

    always_ff @(posedge clk) begin
        if (commit && rst && !cur_rd) begin
            for (int j = 0; j < 4; j++) begin
                if (be[j]) mem[idx][8*j +: 8] <= wbyte[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata    <= '0;
            lat_addr <= '0;
            lat_mask <= '0;
            lat_rd   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    lat_addr <= bus.addr_bus;
                    lat_mask <= bus.data_mask_bus;
                    lat_rd   <= bus.rd_bus;
                    if (wait_sel == 4'd0) begin
                        state <= ACK;
                        cnt   <= '0;
                    end else begin
                        state <= WAIT;
                        cnt   <= wait_sel;
                    end
                end
                WAIT: begin
                    if (!match) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state <= ACK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK:     if (!req) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit && cur_rd) rdata <= rd_word;
        end
    end

    // Reset releases the bus at once, independent of the clock.
    assign bus.fc_oe    = req && rst;
    assign bus.data_oe  = req && bus.rd_bus && (state == ACK) && rst;
    assign bus.fc_bus   = bus.fc_oe ? (state == ACK) : 1'bz;
    assign bus.data_bus = bus.data_oe ? rdata : 'z;
endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram: two instances (zero and three write waits) share
// address/data stimulus; strobes go only to the selected instance.
module tb_bus_ram;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  mask = '0;
    logic        rd = 1'b0, wr = 1'b0, drv = 1'b0;
    logic        sel = 1'b0;
    int          checks = 0, fails = 0;

    bus_ram_if bif0();
    bus_ram_if bif1();

    assign bif0.addr_bus      = addr;
    assign bif0.data_mask_bus = mask;
    assign bif0.rd_bus        = rd & ~sel;
    assign bif0.wr_bus        = wr & ~sel;
    assign bif0.data_bus      = drv ? wdata : 'z;
    assign bif1.addr_bus      = addr;
    assign bif1.data_mask_bus = mask;
    assign bif1.rd_bus        = rd & sel;
    assign bif1.wr_bus        = wr & sel;
    assign bif1.data_bus      = drv ? wdata : 'z;

    bus_ram #(.BASE_ADDR(BASE), .SIZE_WORDS(1024), .READ_WAIT(1), .WRITE_WAIT(0))
        dut0 (.clk(clk), .rst(rst), .bus(bif0));
    bus_ram #(.BASE_ADDR(BASE), .SIZE_WORDS(1024), .READ_WAIT(1), .WRITE_WAIT(3))
        dut1 (.clk(clk), .rst(rst), .bus(bif1));

    wire        fc    = sel ? bif1.fc_bus   : bif0.fc_bus;
    wire        fc_oe = sel ? bif1.fc_oe    : bif0.fc_oe;
    wire        d_oe  = sel ? bif1.data_oe  : bif0.data_oe;
    wire [31:0] rbus  = sel ? bif1.data_bus : bif0.data_bus;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req_on(input logic s, input logic is_rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        @(posedge clk); #1;
        sel = s; addr = a; wdata = d; mask = m;
        rd = is_rd; wr = ~is_rd; drv = ~is_rd;
    endtask

    task automatic req_off();
        rd = 1'b0; wr = 1'b0; drv = 1'b0;
    endtask

    // Edges from request to fc high, sampled at the falling edge; bounded.
    task automatic wait_fc(output int n);
        n = 0;
        do begin
            @(posedge clk); @(negedge clk);
            n++;
        end while (!(fc_oe === 1'b1 && fc === 1'b1) && n < 30);
    endtask

    task automatic xfer(input string tag, input logic s, input logic is_rd,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input int lat, input logic [31:0] exp_d);
        int n;
        req_on(s, is_rd, a, d, m);
        #1;
        chk({tag, " fc low before ack"}, {31'b0, fc_oe & ~fc}, 32'd1);
        wait_fc(n);
        chk({tag, " latency"}, n, lat);
        chk({tag, " data drive"}, {31'b0, d_oe}, {31'b0, is_rd});
        if (is_rd) chk({tag, " rdata"}, rbus, exp_d);
        req_off();
        #1;
        chk({tag, " fc released"}, {31'b0, fc_oe}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] held;

        // Reset holds the bus released even with a request present.
        addr = BASE; rd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset fc_oe", {31'b0, fc_oe}, 32'd0);
        chk("reset data_oe", {31'b0, d_oe}, 32'd0);
        rd = 1'b0;
        @(negedge clk); rst = 1'b1;

        xfer("wr word", 0, 0, BASE + 32'h10, 32'hDEADBEEF, 4'b1111, 1, '0);
        xfer("rd word", 0, 1, BASE + 32'h10, '0, 4'b0000, 2, 32'hDEADBEEF);
        xfer("wr byte", 0, 0, BASE + 32'h12, 32'h0000_00A5, 4'b0001, 1, '0);
        xfer("rd merged", 0, 1, BASE + 32'h10, '0, 4'b1111, 2, 32'hDEA5BEEF);
        xfer("rd off2", 0, 1, BASE + 32'h12, '0, 4'b0001, 2, 32'h0000DEA5);

        // Offset 3 keeps only lane 0; nothing carries into the next word.
        xfer("wr w14", 0, 0, BASE + 32'h14, 32'h0000_0000, 4'b1111, 1, '0);
        xfer("wr w18", 0, 0, BASE + 32'h18, 32'hCAFEF00D, 4'b1111, 1, '0);
        xfer("wr off3", 0, 0, BASE + 32'h17, 32'h12345678, 4'b1111, 1, '0);
        xfer("rd w14", 0, 1, BASE + 32'h14, '0, 4'b0000, 2, 32'h78000000);
        xfer("rd w18", 0, 1, BASE + 32'h18, '0, 4'b0000, 2, 32'hCAFEF00D);

        // Last word of the window is still a hit.
        xfer("wr last", 0, 0, BASE + 32'hFFC, 32'hA0B0C0D0, 4'b1111, 1, '0);
        xfer("rd last", 0, 1, BASE + 32'hFFC, '0, 4'b0000, 2, 32'hA0B0C0D0);

        // Just outside either end, and both strobes at once: no response.
        req_on(0, 1, BASE - 32'h4, '0, 4'b0000);
        repeat (3) @(negedge clk);
        chk("below fc_oe", {31'b0, fc_oe}, 32'd0);
        chk("below data_oe", {31'b0, d_oe}, 32'd0);
        req_off();
        req_on(0, 1, BASE + 32'h1000, '0, 4'b0000);
        repeat (3) @(negedge clk);
        chk("above fc_oe", {31'b0, fc_oe}, 32'd0);
        chk("above data_oe", {31'b0, d_oe}, 32'd0);
        req_off();
        req_on(0, 1, BASE + 32'h10, '0, 4'b0000);
        wr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rd+wr fc_oe", {31'b0, fc_oe}, 32'd0);
        req_off();

        // Abort in WAIT on the three-wait instance.
        xfer("wr3 seed", 1, 0, BASE + 32'h20, 32'h22222222, 4'b1111, 4, '0);
        req_on(1, 0, BASE + 32'h20, 32'h11111111, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            chk("abort waiting", {31'b0, fc_oe & ~fc}, 32'd1);
        end
        req_off();
        repeat (3) @(negedge clk);
        chk("abort no fc", {31'b0, fc_oe}, 32'd0);
        xfer("rd after abort", 1, 1, BASE + 32'h20, '0, 4'b0000, 2, 32'h22222222);

        // Held acknowledge: fc and data stay put, then a fresh read is normal.
        req_on(0, 1, BASE + 32'h10, '0, 4'b0000);
        wait_fc(n);
        chk("held latency", n, 2);
        held = rbus;
        chk("held rdata", held, 32'hDEA5BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held fc", {31'b0, fc_oe & fc}, 32'd1);
            chk("held data", rbus, 32'hDEA5BEEF);
        end
        req_off();
        #1;
        chk("held release", {31'b0, fc_oe}, 32'd0);
        xfer("rd after held", 0, 1, BASE + 32'h18, '0, 4'b0000, 2, 32'hCAFEF00D);

        // Reset during ACK releases the bus immediately.
        req_on(0, 1, BASE + 32'h10, '0, 4'b0000);
        wait_fc(n);
        chk("pre-reset latency", n, 2);
        rst = 1'b0;
        #1;
        chk("mid-ack rst fc_oe", {31'b0, fc_oe}, 32'd0);
        chk("mid-ack rst data_oe", {31'b0, d_oe}, 32'd0);
        @(posedge clk); #1;
        req_off();
        @(negedge clk); rst = 1'b1;
        xfer("rd after rst", 0, 1, BASE + 32'h10, '0, 4'b0000, 2, 32'hDEA5BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/bus_ram.md
# bus_ram

Word-organised RAM that acts as a responder on the shared system bus, on the far side of every bus initiator (CPU, DMA). It decodes a request addressed to its window and inserts a programmable number of wait states. It then commits a masked write or returns right-aligned read data, and signals completion on `fc_bus`. It holds completion until the initiator withdraws the request. Used as main data memory and as the source and destination of DMA byte transfers.

## Interface
- `BASE_ADDR`, 32'h1000_0000, window base; aligned to window size.
- `SIZE_WORDS`, 1024, window size in 32-bit words; power of two, ≥ 2.
- `READ_WAIT`, 1, wait cycles inserted before read completion (0–15).
- `WRITE_WAIT`, 0, wait cycles inserted before write completion (0–15).
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  asynchronous active-low reset.
- `addr_bus`  inout  32  byte address; input only, never driven.
- `data_bus`  inout  32  write data in; read data out while responding.
- `rd_bus`, `wr_bus`  inout  1 each  request strobes; input only.
- `data_mask_bus`  inout  4  byte-lane enables, right-aligned; input only.
- `fc_bus`  inout  1  function complete; driven only while addressed.

## Operation
- Address split:
  - word index = `addr_bus[log2(SIZE_WORDS)+1:2]`;
  - byte offset = `addr_bus[1:0]`;
  - hit = `addr_bus` inside [BASE_ADDR, BASE_ADDR+4·SIZE_WORDS).
- Request decode:
  - valid = `rd_bus ^ wr_bus`; both high or both low is not a request.
  - req = hit && valid.
- Write: lane i (mask bit i) writes `data_bus[8i+7:8i]` to byte offset+i of the addressed word.
  - Lanes with offset+i > 3 are discarded; there is no carry into the next word.
- Read: `data_bus` = stored word >> (8·offset).
  - Upper bytes read as zero.
  - Mask is ignored on reads.
- Read data is captured into an output register on entry to ACK and held stable through ACK.
- State machine:
  - IDLE → WAIT when req; wait counter loads READ_WAIT or WRITE_WAIT; address, offset, mask and direction are latched.
  - IDLE → ACK directly when req and the selected wait is 0.
  - WAIT: counter decrements each cycle; → ACK on the cycle the counter reaches 0.
  - WAIT → IDLE (abort) if req drops or the address/strobe no longer matches the latched values. The write is not committed.
  - ACK: the write is committed on the entry edge, exactly once. Stay in ACK while req is high; → IDLE on the first cycle req is low.
- Bus drive:
  - `fc_bus` = z when !req; 0 in IDLE/WAIT; 1 in ACK.
  - `data_bus` is driven only when req && `rd_bus` && state == ACK; z otherwise.
  - `addr_bus`, `rd_bus`, `wr_bus` and `data_mask_bus` are permanently z.
- Back-to-back requests: a new request is accepted only after one IDLE cycle. An initiator that keeps strobes high after `fc_bus` is a protocol error; the block stays in ACK.
- Memory contents are not reset. Simulation initial value is X.

## Timing
- Latency: request present before edge E0; `fc_bus` rises after edge E0+W, where W is the selected wait.
  - W=0: fc is high during the cycle after E0.
- Write data is sampled at E0+W, not at E0. The initiator holds `data_bus` until fc is seen.
- `fc_bus` falls combinationally (goes z) in the same cycle req drops. The state returns to IDLE on the next edge.
- Reset (`rst` low, any time, including mid-WAIT or mid-ACK):
  - state → IDLE, counter → 0, output register → 0;
  - `fc_bus` and `data_bus` go z immediately;
  - a write not yet committed is lost.
- Simultaneous: a request arriving in the same cycle `rst` deasserts is ignored that cycle and sampled on the next edge.

## Test plan
- Full-word write, then read.
  - Stimulus (WRITE_WAIT=0, READ_WAIT=1): write `32'hDEADBEEF` to BASE+0x10, mask 4'b1111; then read BASE+0x10.
  - Response: write fc 1 cycle after the request; read fc 2 cycles after the request; `data_bus` = `32'hDEADBEEF`.
- Byte write at offset 2, then reads.
  - Stimulus: byte write `8'hA5` at BASE+0x12, mask 4'b0001, over the prior word; then word read at BASE+0x10 and byte read at BASE+0x12.
  - Response: word read = `32'hDEA5BEEF`; byte read `data_bus[7:0]` = `8'hA5`, upper bytes = `24'h0000DE`.
- Out-of-window request.
  - Stimulus: read at BASE−4 and at BASE+4·SIZE_WORDS.
  - Response: `fc_bus` and `data_bus` stay z; state stays IDLE.
- Abort in WAIT.
  - Stimulus: WRITE_WAIT=3; write `32'h11111111` to BASE+0x20; drop `wr_bus` after 2 cycles; then read BASE+0x20.
  - Response: no fc on the write; the read returns the previous contents.
- Held acknowledge.
  - Stimulus: hold the read request for 5 cycles after fc.
  - Response: fc and data stay stable for all 5 cycles; exactly one completion; IDLE one cycle after release.
- Reset mid-operation.
  - Stimulus: assert `rst` low during ACK of a read.
  - Response: `fc_bus`/`data_bus` go z in the same cycle; after release, a new request is served normally.
